// File: rtl/counter_mon_pkg.sv
// rtl/counter_mon_pkg.sv - shared types and reference-model next-state helpers for counter_monitor
// Contents:
//   mon_state_t       monitor FSM encoding (IDLE=0, SYNC=1, CHECK=2, HALT=3)
//   model_next_val    next counter value from current value + controls
//   model_next_carry  next carry/borrow flag from current value + controls
// The helpers work on MAX_W-bit vectors and mask to the caller's width, so
// any counter width up to MAX_W can share one definition.
package counter_mon_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } mon_state_t;

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
    if (width >= MAX_W) begin
      return '1;
    end
    return (MAX_W'(1) << width) - MAX_W'(1);
  endfunction

  // Load has priority over counting; an idle cycle holds the value.
  function automatic logic [MAX_W-1:0] model_next_val(
    input logic [MAX_W-1:0] val,
    input logic [MAX_W-1:0] in_val,
    input logic             load,
    input logic             up_down,
    input logic             count_en,
    input int unsigned      width
  );
    logic [MAX_W-1:0] mask;
    mask = width_mask(width);
    if (load) begin
      return in_val & mask;
    end
    if (!count_en) begin
      return val & mask;
    end
    if (up_down) begin
      return (val + MAX_W'(1)) & mask;
    end
    return (val - MAX_W'(1)) & mask;
  endfunction

  // Carry is a one-cycle flag raised only on the wrapping count step.
  function automatic logic model_next_carry(
    input logic [MAX_W-1:0] val,
    input logic             load,
    input logic             up_down,
    input logic             count_en,
    input int unsigned      width
  );
    logic [MAX_W-1:0] mask;
    mask = width_mask(width);
    if (load || !count_en) begin
      return 1'b0;
    end
    if (up_down) begin
      return (val & mask) == mask;
    end
    return (val & mask) == '0;
  endfunction

endpackage

// File: rtl/counter_ref_model.sv
// rtl/counter_ref_model.sv - cycle-accurate reference copy of the observed counter
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   track               advance the model this cycle (hold otherwise)
//   seed                use seed_val instead of exp_val as the base value
//   load, in_val        observed load strobe and value
//   up_down, count_en   observed direction (1 = up) and count enable
//   seed_val            observed counter output, used when seeding
//   exp_val, exp_carry  expected counter output and carry for the next edge
module counter_ref_model
  import counter_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             track,
  input  logic             seed,
  input  logic             load,
  input  logic [WIDTH-1:0] in_val,
  input  logic             up_down,
  input  logic             count_en,
  input  logic [WIDTH-1:0] seed_val,
  output logic [WIDTH-1:0] exp_val,
  output logic             exp_carry
);

  logic [WIDTH-1:0] base_val;
  logic [WIDTH-1:0] next_val;
  logic             next_carry;

  // When seeding, the observed output already reflects the previous edge's
  // controls, so stepping it with the current controls predicts the next one.
  assign base_val   = seed ? seed_val : exp_val;
  assign next_val   = WIDTH'(model_next_val(MAX_W'(base_val), MAX_W'(in_val),
                                            load, up_down, count_en, WIDTH));
  assign next_carry = model_next_carry(MAX_W'(base_val), load, up_down, count_en, WIDTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_val   <= '0;
      exp_carry <= 1'b0;
    end else if (track) begin
      exp_val   <= next_val;
      exp_carry <= next_carry;
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - passive checker comparing a counter against its own reference model
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   chk_en                          checking enable
//   mon_load, mon_in_val            observed load strobe / value
//   mon_up_down, mon_count_en       observed direction / count enable
//   mon_out_val, mon_carry_out      observed counter output / carry
//   err                             one-cycle mismatch pulse
//   err_sticky                      set on first mismatch until reset
//   err_cnt, chk_cnt                saturating mismatch / compare counters
//   first_exp_val, first_got_val    expected / observed value at first mismatch
//   first_err_cyc                   chk_cnt at first mismatch
//   state                           IDLE=0, SYNC=1, CHECK=2, HALT=3
module counter_monitor
  import counter_mon_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             mon_load,
  input  logic [WIDTH-1:0] mon_in_val,
  input  logic             mon_up_down,
  input  logic             mon_count_en,
  input  logic [WIDTH-1:0] mon_out_val,
  input  logic             mon_carry_out,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [WIDTH-1:0] first_exp_val,
  output logic [WIDTH-1:0] first_got_val,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [1:0]       state
);

  mon_state_t       cur_state;
  mon_state_t       next_state;
  logic [WIDTH-1:0] exp_val;
  logic             exp_carry;
  logic             do_cmp;
  logic             mismatch;
  logic             model_track;
  logic             model_seed;

  // Dropping chk_en in CHECK suppresses the compare on that same edge.
  assign do_cmp   = (cur_state == ST_CHECK) && chk_en;
  assign mismatch = do_cmp && ((mon_out_val != exp_val) || (mon_carry_out != exp_carry));

  assign model_seed  = (cur_state == ST_SYNC);
  assign model_track = (cur_state == ST_SYNC) || (cur_state == ST_CHECK);

  counter_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref_model (
    .clk      (clk),
    .rst      (rst),
    .track    (model_track),
    .seed     (model_seed),
    .load     (mon_load),
    .in_val   (mon_in_val),
    .up_down  (mon_up_down),
    .count_en (mon_count_en),
    .seed_val (mon_out_val),
    .exp_val  (exp_val),
    .exp_carry(exp_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE:  if (chk_en) next_state = ST_SYNC;
      ST_SYNC:  next_state = chk_en ? ST_CHECK : ST_IDLE;
      ST_CHECK: begin
        if (!chk_en) begin
          next_state = ST_IDLE;
        end else if (mismatch && STOP_ON_ERR) begin
          next_state = ST_HALT;
        end
      end
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err           <= 1'b0;
      err_sticky    <= 1'b0;
      err_cnt       <= '0;
      chk_cnt       <= '0;
      first_exp_val <= '0;
      first_got_val <= '0;
      first_err_cyc <= '0;
    end else begin
      err <= mismatch;
      if (do_cmp && (chk_cnt != '1)) begin
        chk_cnt <= chk_cnt + CNT_W'(1);
      end
      if (mismatch) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        // Capture uses the pre-increment compare count of the failing cycle.
        if (!err_sticky) begin
          err_sticky    <= 1'b1;
          first_exp_val <= exp_val;
          first_got_val <= mon_out_val;
          first_err_cyc <= chk_cnt;
        end
      end
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_counter_monitor.sv
// tb/tb_counter_monitor.sv - directed self-checking bench for counter_monitor
module tb_counter_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       chk_en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] in_val = 8'h00;
  logic       up_down = 1'b1;
  logic       count_en = 1'b0;
  logic       inject = 1'b0;
  logic [7:0] inj_xor = 8'h00;

  logic [7:0] ctr;
  logic       ctr_carry;
  logic [7:0] mon_out_val;

  // Stand-in for the real counter under observation.
  always @(posedge clk) begin
    if (!rst) begin
      ctr <= 8'h00;
      ctr_carry <= 1'b0;
    end else if (load) begin
      ctr <= in_val;
      ctr_carry <= 1'b0;
    end else if (count_en && up_down) begin
      ctr <= ctr + 8'h01;
      ctr_carry <= (ctr == 8'hFF);
    end else if (count_en) begin
      ctr <= ctr - 8'h01;
      ctr_carry <= (ctr == 8'h00);
    end else begin
      ctr_carry <= 1'b0;
    end
  end

  assign mon_out_val = inject ? (ctr ^ inj_xor) : ctr;

  logic        a_err, a_sticky;
  logic [15:0] a_err_cnt, a_chk_cnt, a_fcyc;
  logic [7:0]  a_fexp, a_fgot;
  logic [1:0]  a_state;
  logic        b_err, b_sticky;
  logic [3:0]  b_err_cnt, b_chk_cnt, b_fcyc;
  logic [7:0]  b_fexp, b_fgot;
  logic [1:0]  b_state;
  logic        h_err, h_sticky;
  logic [15:0] h_err_cnt, h_chk_cnt, h_fcyc;
  logic [7:0]  h_fexp, h_fgot;
  logic [1:0]  h_state;

  counter_monitor #(.WIDTH(8), .CNT_W(16), .STOP_ON_ERR(1'b0)) dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .mon_load(load), .mon_in_val(in_val),
    .mon_up_down(up_down), .mon_count_en(count_en), .mon_out_val(mon_out_val),
    .mon_carry_out(ctr_carry), .err(a_err), .err_sticky(a_sticky), .err_cnt(a_err_cnt),
    .chk_cnt(a_chk_cnt), .first_exp_val(a_fexp), .first_got_val(a_fgot),
    .first_err_cyc(a_fcyc), .state(a_state)
  );

  counter_monitor #(.WIDTH(8), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .chk_en(chk_en), .mon_load(load), .mon_in_val(in_val),
    .mon_up_down(up_down), .mon_count_en(count_en), .mon_out_val(mon_out_val),
    .mon_carry_out(ctr_carry), .err(b_err), .err_sticky(b_sticky), .err_cnt(b_err_cnt),
    .chk_cnt(b_chk_cnt), .first_exp_val(b_fexp), .first_got_val(b_fgot),
    .first_err_cyc(b_fcyc), .state(b_state)
  );

  counter_monitor #(.WIDTH(8), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut_halt (
    .clk(clk), .rst(rst), .chk_en(chk_en), .mon_load(load), .mon_in_val(in_val),
    .mon_up_down(up_down), .mon_count_en(count_en), .mon_out_val(mon_out_val),
    .mon_carry_out(ctr_carry), .err(h_err), .err_sticky(h_sticky), .err_cnt(h_err_cnt),
    .chk_cnt(h_chk_cnt), .first_exp_val(h_fexp), .first_got_val(h_fgot),
    .first_err_cyc(h_fcyc), .state(h_state)
  );

  int a_err_total = 0;
  always @(negedge clk) begin
    if (a_err === 1'b1) a_err_total <= a_err_total + 1;
  end

  int tests = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_sticky", 32'(a_sticky), 32'd0);
    check("rst_err_cnt", 32'(a_err_cnt), 32'd0);
    check("rst_chk_cnt", 32'(a_chk_cnt), 32'd0);
    check("rst_first_exp", 32'(a_fexp), 32'd0);
    check("rst_first_got", 32'(a_fgot), 32'd0);
    check("rst_first_cyc", 32'(a_fcyc), 32'd0);

    // Count up across the 255->0 wrap: 301 edges = IDLE, SYNC, 299 compares
    rst = 1'b1;
    chk_en = 1'b1;
    count_en = 1'b1;
    up_down = 1'b1;
    repeat (301) tick();
    check("up_chk_cnt", 32'(a_chk_cnt), 32'd299);
    check("up_err_cnt", 32'(a_err_cnt), 32'd0);
    check("up_state", 32'(a_state), 32'd2);
    check("up_sticky", 32'(a_sticky), 32'd0);
    check("sat4_chk_cnt", 32'(b_chk_cnt), 32'd15);

    // Load 0x7F with count_en also high, then count down through 0x00->0xFF
    load = 1'b1;
    in_val = 8'h7F;
    tick();
    load = 1'b0;
    up_down = 1'b0;
    repeat (128) tick();
    check("down_chk_cnt", 32'(a_chk_cnt), 32'd428);
    check("down_err_cnt", 32'(a_err_cnt), 32'd0);
    check("down_err_total", 32'(a_err_total), 32'd0);

    // Fresh run: load 0xE9 on the SYNC-entry edge so 0x12 is expected at chk_cnt=40
    rst = 1'b0;
    chk_en = 1'b0;
    count_en = 1'b0;
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
    load = 1'b1;
    in_val = 8'hE9;
    count_en = 1'b1;
    up_down = 1'b1;
    tick();
    load = 1'b0;
    repeat (41) tick();
    check("pre_err", 32'(a_err), 32'd0);
    check("pre_sticky", 32'(a_sticky), 32'd0);
    inject = 1'b1;
    inj_xor = 8'h01;
    tick();
    inject = 1'b0;
    check("inj_err", 32'(a_err), 32'd1);
    check("inj_sticky", 32'(a_sticky), 32'd1);
    check("inj_first_exp", 32'(a_fexp), 32'h12);
    check("inj_first_got", 32'(a_fgot), 32'h13);
    check("inj_first_cyc", 32'(a_fcyc), 32'd40);
    check("inj_err_cnt", 32'(a_err_cnt), 32'd1);
    check("halt_state", 32'(h_state), 32'd3);
    check("halt_chk_cnt", 32'(h_chk_cnt), 32'd41);
    tick();
    check("err_one_cycle", 32'(a_err), 32'd0);

    // 20 further mismatches: 4-bit counter saturates, first capture stays put
    inject = 1'b1;
    repeat (20) tick();
    inject = 1'b0;
    tick();
    check("many_err_cnt", 32'(a_err_cnt), 32'd21);
    check("sat4_err_cnt", 32'(b_err_cnt), 32'd15);
    check("sat4_first_exp", 32'(b_fexp), 32'h12);
    check("sat4_first_got", 32'(b_fgot), 32'h13);
    check("sat4_first_cyc", 32'(b_fcyc), 32'd15);
    check("many_first_exp", 32'(a_fexp), 32'h12);
    check("many_first_cyc", 32'(a_fcyc), 32'd40);
    check("many_chk_cnt", 32'(a_chk_cnt), 32'd63);
    check("halt_chk_frozen", 32'(h_chk_cnt), 32'd41);
    check("halt_err_frozen", 32'(h_err_cnt), 32'd1);
    check("halt_still", 32'(h_state), 32'd3);
    check("many_err_clear", 32'(a_err), 32'd0);

    // Drop chk_en for 5 cycles while counter is loaded to 0xA0, then resync
    chk_en = 1'b0;
    load = 1'b1;
    in_val = 8'hA0;
    tick();
    load = 1'b0;
    repeat (4) tick();
    check("off_state", 32'(a_state), 32'd0);
    check("off_chk_cnt", 32'(a_chk_cnt), 32'd63);
    chk_en = 1'b1;
    tick();
    check("resync_state", 32'(a_state), 32'd1);
    repeat (9) tick();
    check("resync_check", 32'(a_state), 32'd2);
    check("resync_chk_cnt", 32'(a_chk_cnt), 32'd71);
    check("resync_err_cnt", 32'(a_err_cnt), 32'd21);
    check("resync_err_total", 32'(a_err_total), 32'd21);

    // Reset releases HALT and discards all history
    rst = 1'b0;
    tick();
    check("rst2_halt_state", 32'(h_state), 32'd0);
    check("rst2_halt_chk", 32'(h_chk_cnt), 32'd0);
    check("rst2_halt_err", 32'(h_err_cnt), 32'd0);
    check("rst2_sticky", 32'(a_sticky), 32'd0);
    check("rst2_first_exp", 32'(a_fexp), 32'd0);
    check("rst2_first_cyc", 32'(a_fcyc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
